back_bus_pipe: RTL and testbench

Pipeline back-path producer for the forwarding unit. Holds the EX/MEM and MEM/WB result slots and drives `MEM_BACK`/`WB_BACK` as `{regWrite, Wd[31:0], rd[4:0]}` bundles with their `USE_*` qualifiers. Detects load-use hazards and stalls the pipe while a load waits on variable-latency data memory, with a bounded wait. Sits between the EX stage output and the register-file write port; the forwarding unit in EX consumes its outputs.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/load_wait_ctr.sv | 44 ++++
 rtl/back_bus_pipe.sv | 133 +++++++++++++
 tb/tb_back_bus_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline back-path: the 38-bit forwarding bundle
// and the MEM slot state encoding.
package pipe_pkg;

  localparam int BACK_W = 38;
  localparam int CTR_W  = 8;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ALU       = 2'd1,
    LOAD_WAIT = 2'd2
  } mem_slot_e;

  typedef struct packed {
    logic        regWrite;
    logic [31:0] Wd;
    logic [4:0]  rd;
  } back_bus_t;

  // A destination matches a source only when it is a real register.
  function automatic logic reg_match(
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/load_wait_ctr.sv
// Wait counter for a load parked in MEM: decodes data return and the
// bounded-wait timeout.
module load_wait_ctr
  import pipe_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic waiting,
  input  logic rvalid,
  output logic retire,
  output logic timeout
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(LOAD_TIMEOUT - 1);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;
  logic             at_last;

  always_comb begin
    at_last = (cnt_q == LAST);
    retire  = waiting && (rvalid || at_last);
    timeout = waiting && !rvalid && at_last;
    cnt_d   = cnt_q;
    // A new load restarts the count even if the old one retires now.
    if (start) begin
      cnt_d = '0;
    end else if (waiting && !retire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/back_bus_pipe.sv
// EX/MEM and MEM/WB result slots feeding the forwarding unit, with
// load-use hazard detection and a bounded load-wait stall.
module back_bus_pipe
  import pipe_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  input  logic [4:0]        ex_rd,
  input  logic [31:0]       ex_result,
  input  logic              flush,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_rvalid,
  output logic [BACK_W-1:0] MEM_BACK,
  output logic [BACK_W-1:0] WB_BACK,
  output logic              USE_MEM_BACK,
  output logic              USE_WB_BACK,
  output logic              stall_id,
  output logic              stall_mem,
  output logic              load_timeout
);

  mem_slot_e state_q;
  mem_slot_e state_d;
  back_bus_t mem_q;
  back_bus_t mem_d;
  back_bus_t wb_q;
  back_bus_t wb_d;
  logic      to_q;
  logic      to_d;

  logic ld_waiting;
  logic ld_start;
  logic ld_retire;
  logic ld_timeout;
  logic kill;

  assign ld_waiting = (state_q == LOAD_WAIT);
  assign kill       = !ex_valid || flush;

  load_wait_ctr #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (ld_start),
    .waiting(ld_waiting),
    .rvalid (dmem_rvalid),
    .retire (ld_retire),
    .timeout(ld_timeout)
  );

  always_comb begin
    stall_mem = ld_waiting && !ld_retire;
    state_d   = state_q;
    mem_d     = mem_q;
    ld_start  = 1'b0;
    // While stalled the MEM slot is older than EX, so flush cannot touch it.
    if (!stall_mem) begin
      mem_d = '0;
      unique case (1'b1)
        kill: begin
          state_d = EMPTY;
        end
        (!kill && ex_memRead): begin
          state_d        = LOAD_WAIT;
          ld_start       = 1'b1;
          mem_d.regWrite = ex_regWrite;
          mem_d.rd       = ex_rd;
        end
        (!kill && !ex_memRead): begin
          state_d        = ALU;
          mem_d.regWrite = ex_regWrite;
          mem_d.Wd       = ex_result;
          mem_d.rd       = ex_rd;
        end
      endcase
    end
  end

  always_comb begin
    wb_d = '0;
    to_d = ld_timeout;
    unique case (1'b1)
      (state_q == ALU): begin
        wb_d = mem_q;
      end
      (ld_retire && !ld_timeout): begin
        wb_d    = mem_q;
        wb_d.Wd = dmem_rdata;
      end
      ld_timeout: begin
        wb_d.rd = mem_q.rd;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      mem_q   <= '0;
      wb_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      to_q    <= to_d;
    end
  end

  assign MEM_BACK     = (state_q == EMPTY) ? '0 : mem_q;
  assign WB_BACK      = wb_q;
  assign USE_MEM_BACK = (state_q == ALU) && mem_q.regWrite;
  assign USE_WB_BACK  = wb_q.regWrite && (wb_q.rd != 5'd0);
  assign load_timeout = to_q;

  // Gated by reset so every output reads 0 while rst_n is low.
  assign stall_id = rst_n && ex_valid && !flush && ex_memRead &&
                    ex_regWrite &&
                    (reg_match(ex_rd, id_rs) ||
                     (id_uses_rt && reg_match(ex_rd, id_rt)));

endmodule

// File: tb/tb_back_bus_pipe.sv
// Scoreboard bench for back_bus_pipe: expected WB writes are queued at
// issue and compared when the WB slot presents a register write.
module tb_back_bus_pipe;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_regWrite;
  logic        ex_memRead;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        flush;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [37:0] MEM_BACK;
  logic [37:0] WB_BACK;
  logic        USE_MEM_BACK;
  logic        USE_WB_BACK;
  logic        stall_id;
  logic        stall_mem;
  logic        load_timeout;

  int errors = 0;
  int checks = 0;
  logic [37:0] sb[$];

  back_bus_pipe #(.LOAD_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_regWrite (ex_regWrite),
    .ex_memRead  (ex_memRead),
    .ex_rd       (ex_rd),
    .ex_result   (ex_result),
    .flush       (flush),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .MEM_BACK    (MEM_BACK),
    .WB_BACK     (WB_BACK),
    .USE_MEM_BACK(USE_MEM_BACK),
    .USE_WB_BACK (USE_WB_BACK),
    .stall_id    (stall_id),
    .stall_mem   (stall_mem),
    .load_timeout(load_timeout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [37:0] e;
    if (rst_n && WB_BACK[37]) begin
      if (sb.size() == 0) begin
        check("wb_extra", 64'(WB_BACK), 64'd0);
      end else begin
        e = sb.pop_front();
        check("wb_data", 64'(WB_BACK), 64'(e));
      end
    end
  end

  task automatic issue(input logic ld, input logic [4:0] rd,
                       input logic [31:0] res);
    ex_valid    = 1'b1;
    ex_regWrite = 1'b1;
    ex_memRead  = ld;
    ex_rd       = rd;
    ex_result   = res;
  endtask

  task automatic idle();
    ex_valid   = 1'b0;
    ex_memRead = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    int use_seen;
    rst_n = 1'b0;
    ex_valid = 0; ex_regWrite = 0; ex_memRead = 0; ex_rd = 0;
    ex_result = 0; flush = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    dmem_rdata = 0; dmem_rvalid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem", 64'(MEM_BACK), 64'd0);
    check("rst_wb", 64'(WB_BACK), 64'd0);
    check("rst_stall_mem", 64'(stall_mem), 64'd0);
    check("rst_use_wb", 64'(USE_WB_BACK), 64'd0);
    rst_n = 1'b1;

    // ALU result travels MEM then WB
    @(posedge clk); #1;
    issue(1'b0, 5'd3, 32'h11);
    sb.push_back({1'b1, 32'h11, 5'd3});
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("alu_mem", 64'(MEM_BACK), 64'({1'b1, 32'h11, 5'd3}));
    check("alu_use_mem", 64'(USE_MEM_BACK), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("alu_use_wb", 64'(USE_WB_BACK), 64'd1);
    check("alu_mem_clr", 64'(MEM_BACK), 64'd0);

    // load-use hazard decode, all within one half period
    issue(1'b1, 5'd5, 32'h0);
    id_rs = 5'd5; id_uses_rt = 1'b0; id_rt = 5'd0;
    #1 check("sid_rs", 64'(stall_id), 64'd1);
    id_rs = 5'd0; id_uses_rt = 1'b1; id_rt = 5'd5;
    #1 check("sid_rt", 64'(stall_id), 64'd1);
    id_uses_rt = 1'b0;
    #1 check("sid_no_rt", 64'(stall_id), 64'd0);
    id_rs = 5'd5; flush = 1'b1;
    #1 check("sid_flush", 64'(stall_id), 64'd0);
    flush = 1'b0; ex_rd = 5'd0; id_rs = 5'd0;
    #1 check("sid_r0", 64'(stall_id), 64'd0);
    idle();
    id_rs = 5'd0;

    // zero-wait load
    @(posedge clk); #1;
    issue(1'b1, 5'd6, 32'hFFFF);
    sb.push_back({1'b1, 32'hA5A55A5A, 5'd6});
    @(posedge clk); #1;
    idle();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A55A5A;
    @(negedge clk);
    check("zw_stall", 64'(stall_mem), 64'd0);
    check("zw_use_mem", 64'(USE_MEM_BACK), 64'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("zw_use_wb", 64'(USE_WB_BACK), 64'd1);

    // load with data on the third MEM cycle
    @(posedge clk); #1;
    issue(1'b1, 5'd5, 32'h0);
    sb.push_back({1'b1, 32'hCAFEF00D, 5'd5});
    @(posedge clk); #1;
    idle();
    stalls = 0; use_seen = 0;
    for (int k = 0; k < 10; k++) begin
      dmem_rvalid = (k == 2);
      dmem_rdata  = (k == 2) ? 32'hCAFEF00D : 32'h0BAD0BAD;
      @(negedge clk);
      if (USE_MEM_BACK) use_seen++;
      if (!stall_mem) break;
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("k2_stalls", 64'(stalls), 64'd2);
    check("k2_use_mem", 64'(use_seen), 64'd0);
    @(negedge clk);
    check("k2_use_wb", 64'(USE_WB_BACK), 64'd1);

    // timeout, with a flushed EX instruction arriving mid-stall
    @(posedge clk); #1;
    issue(1'b1, 5'd7, 32'h0);
    @(posedge clk); #1;
    idle();
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        issue(1'b0, 5'd9, 32'hDEAD);
        flush = 1'b1;
      end else begin
        idle();
      end
      @(negedge clk);
      if (k == 1)
        check("to_flush_kept", 64'(MEM_BACK), 64'({1'b1, 32'h0, 5'd7}));
      if (!stall_mem) break;
      stalls++;
      @(posedge clk); #1;
    end
    idle();
    check("to_stalls", 64'(stalls), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_pulse", 64'(load_timeout), 64'd1);
    check("to_wb_rw", 64'(WB_BACK[37]), 64'd0);
    check("to_wb_wd", 64'(WB_BACK[36:5]), 64'd0);
    check("to_use_wb", 64'(USE_WB_BACK), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_pulse_end", 64'(load_timeout), 64'd0);

    // flushed load never occupies MEM
    @(posedge clk); #1;
    issue(1'b1, 5'd8, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("fl_mem", 64'(MEM_BACK), 64'd0);
    check("fl_stall", 64'(stall_mem), 64'd0);

    // reset during a load wait
    @(posedge clk); #1;
    issue(1'b1, 5'd4, 32'h0);
    id_rs = 5'd4;
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_stall", 64'(stall_mem), 64'd1);
    check("rw_mem", 64'(MEM_BACK), 64'({1'b1, 32'h0, 5'd4}));
    #2 rst_n = 1'b0;
    #1;
    check("ar_mem", 64'(MEM_BACK), 64'd0);
    check("ar_wb", 64'(WB_BACK), 64'd0);
    check("ar_use", 64'({USE_MEM_BACK, USE_WB_BACK}), 64'd0);
    check("ar_stalls", 64'({stall_id, stall_mem}), 64'd0);
    check("ar_to", 64'(load_timeout), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    id_rs = 5'd0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("ar_rv_wb", 64'(WB_BACK), 64'd0);
    check("ar_rv_mem", 64'(MEM_BACK), 64'd0);
    check("ar_rv_stall", 64'(stall_mem), 64'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
